// File: rtl/e_mdu_seq.sv
// Execute-stage multiply/divide sequencer: computes the result on issue, then
// holds a fixed busy window before committing it to the architectural HI/LO.
module e_mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic        accept_md, wr_hi, wr_lo, finish;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;
    logic [3:0]  cnt_load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_md) state_nxt = RUN;
            RUN:     if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode; starts arriving while RUN are dropped here.
    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        accept_md = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        finish    = 1'b0;
        if (state == IDLE && start) begin
            case (MDUOp)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept_md = 1'b1;
                OP_MTHI: wr_hi = 1'b1;
                OP_MTLO: wr_lo = 1'b1;
                default: ;
            endcase
        end
        if (state == RUN && cnt == 4'd0) finish = 1'b1;
    end

    // Result datapath, evaluated in the issue cycle and parked in pend_*.
    always_comb begin
        prod     = '0;
        res_hi   = '0;
        res_lo   = '0;
        res_wr   = 1'b1;
        cnt_load = DIV_LOAD;
        case (MDUOp)
            OP_MULT: begin
                prod     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi   = prod[63:32];
                res_lo   = prod[31:0];
                cnt_load = MULT_LOAD;
            end
            OP_MULTU: begin
                prod     = {32'd0, A} * {32'd0, B};
                res_hi   = prod[63:32];
                res_lo   = prod[31:0];
                cnt_load = MULT_LOAD;
            end
            OP_DIV: begin
                if (B == 32'd0) begin
                    res_wr = 1'b0;
                end else if (B == 32'hFFFF_FFFF) begin
                    // x / -1 is just negation; this also wraps 0x80000000 without overflow.
                    res_lo = 32'd0 - A;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(A) / $signed(B);
                    res_hi = $signed(A) % $signed(B);
                end
            end
            OP_DIVU: begin
                if (B == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

    // Counter, busy flag, pending result and architectural HI/LO.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            if (accept_md) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
                cnt     <= cnt_load;
                busy    <= 1'b1;
            end else if (state == RUN && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
        end
    end

endmodule

// File: tb/tb_e_mdu_seq.sv
// Self-checking bench for e_mdu_seq: directed cases plus random traffic, every
// cycle compared against an arithmetic reference model of the HI/LO unit.
module tb_e_mdu_seq;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst, st;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    int n_proto  = 0;

    // Reference model: remaining busy cycles plus the result waiting to commit.
    int          m_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_pwr = 0;

    e_mdu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (rst),
        .start (st),
        .MDUOp (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_compute();
        longint          sa, sb, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        m_pwr = 1;
        case (op)
            3'd1: begin q = sa * sb; m_phi = q[63:32]; m_plo = q[31:0]; end
            3'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; end
            3'd3: if (b == 0) m_pwr = 0;
                  else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
            default: if (b == 0) m_pwr = 0;
                  else begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
        endcase
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left = 0; m_hi = 0; m_lo = 0; m_pwr = 0;
        end else if (m_left > 0) begin
            if (st) n_proto++;
            m_left--;
            if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                m_left = (op <= 3'd2) ? MULT_N : DIV_N;
                model_compute();
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_left > 0});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        st = s; op = o; a = x; b = y;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        drive(1'b1, o, x, y);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // Counts busy cycles from the issue cycle; bounded so a stuck busy still ends.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;
        tick();

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult_busy_len", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // Issued in the cycle busy falls: must start a fresh window immediately.
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("multu_busy_len", 32'(n), 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'd1);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_busy_len", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd0);
        wait_idle(n);
        check("divz_busy_len", 32'(n), 32'd10);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        drive(1'b1, 3'd5, 32'h1234, 32'd0);
        tick();
        check("mthi_busy", {31'd0, busy}, 32'd0);
        drive(1'b1, 3'd6, 32'h5678, 32'd0);
        tick();
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mtlo_lo", lo, 32'h5678);

        // mtlo during the busy window is ignored; reset mid-window aborts the divide.
        issue(3'd3, 32'd100, 32'd7);
        tick();
        tick();
        $display("note: start while busy (protocol violation, expected to be ignored)");
        drive(1'b1, 3'd6, 32'd1, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("ignored_lo", lo, 32'h5678);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (12) tick();
        check("abort_nowrite_hi", hi, 32'd0);
        check("abort_nowrite_lo", lo, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 119) == 0);
            drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick());
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (12) tick();

        $display("protocol notes: %0d starts issued while busy", n_proto);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
